conv_output_collector: RTL

- Sink-side companion to the Laplacian convolution stage.
- Takes the stage's free-running outputPixel/valid pair and re-aligns valid to the pixel it qualifies.
- Tags each kept pixel with frame position (start of frame, end of line, end of frame) and buffers it in a FIFO.
- Presents the pixels downstream on a valid/ready stream, absorbing back-pressure that the convolution cannot honour.

---
 rtl/conv_output_collector.sv | 122 ++++++++++++
 1 files changed

// File: rtl/conv_output_collector.sv
// Realigns the convolution stage's valid to its pixel, tags frame position and buffers samples
// in a FIFO behind a valid/ready stream. Optional binarisation: CONV_COLLECT_THRESHOLD_EN.
module conv_output_collector #(
  parameter int WORD_SIZE     = 8,
  parameter int ROW_SIZE      = 540,
  parameter int COL_SIZE      = 540,
  parameter int VALID_LATENCY = 3,
  parameter int FIFO_DEPTH    = 16,
  parameter int THRESHOLD     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_SIZE-1:0]          pixel_in,
  input  logic [1:0]                    valid_in,
  output logic [WORD_SIZE-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic                          m_eof,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int OUT_COLS = ROW_SIZE - 2;
  localparam int OUT_ROWS = COL_SIZE - 2;
  localparam int CW       = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int RW       = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int EW       = WORD_SIZE + 3;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || THRESHOLD < 0)
  begin : g_bad_param
    $error("conv_output_collector: invalid FIFO_DEPTH or THRESHOLD");
  end

  // Valid alignment
  logic s_valid;

  if (VALID_LATENCY == 0) begin : g_no_delay
    assign s_valid = |valid_in;
  end else begin : g_delay
    logic [VALID_LATENCY-1:0] vld_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= |valid_in;
        for (int i = 1; i < VALID_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
    end
    assign s_valid = vld_q[VALID_LATENCY-1];
  end

  // Frame position counters; they advance even for dropped samples
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          at_sof, at_eol, at_eof;

  assign at_sof = (row_q == '0) && (col_q == '0);
  assign at_eol = (col_q == CW'(OUT_COLS - 1));
  assign at_eof = at_eol && (row_q == RW'(OUT_ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (s_valid) begin
      if (at_eol) begin
        col_q <= '0;
        row_q <= at_eof ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  logic [WORD_SIZE-1:0] wr_pix;

`ifdef CONV_COLLECT_THRESHOLD_EN
  assign wr_pix = (32'(pixel_in) >= THRESHOLD) ? '1 : '0;
`else
  assign wr_pix = pixel_in;
`endif

  // FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, push, pop;
  logic [EW-1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && m_ready;
  // When full, a same-cycle pop frees the slot being written
  assign push  = s_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (s_valid && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {at_eof, at_eol, at_sof, wr_pix};
  end

  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign m_valid = !empty;
  assign m_data  = empty ? '0 : head[WORD_SIZE-1:0];
  assign m_sof   = !empty && head[WORD_SIZE];
  assign m_eol   = !empty && head[WORD_SIZE+1];
  assign m_eof   = !empty && head[WORD_SIZE+2];
  assign level   = wr_ptr_q - rd_ptr_q;

endmodule
